// File: rtl/cmach_pkg.sv
// Shared types and constants for the coffee machine brew sequencer.
// Holds the state enum, drink/size codes, fixed step times and the recipe layout.
// Helper functions give per-step durations and the next non-skipped step.
package cmach_pkg;

  localparam int NUM_RECIPES = 15;
  localparam int NUM_SIZES   = 3;
  localparam int NUM_DRINKS  = 5;

  localparam logic [2:0] DRINK_MOCHA     = 3'd0;
  localparam logic [2:0] DRINK_LATTE     = 3'd1;
  localparam logic [2:0] DRINK_ESPRESSO  = 3'd2;
  localparam logic [2:0] DRINK_AMERICANO = 3'd3;
  localparam logic [2:0] DRINK_DRIP      = 3'd4;

  localparam logic [1:0] SIZE_S = 2'd0;
  localparam logic [1:0] SIZE_M = 2'd1;
  localparam logic [1:0] SIZE_L = 2'd2;

  // Fixed durations (time units) for the flag-enabled steps.
  localparam logic [3:0] FILTER_TIME = 4'd2;
  localparam logic [3:0] CREAM_TIME  = 4'd2;

  // Step order is significant: the next-step search walks upward through it.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILTER = 3'd1,
    ST_GRIND  = 3'd2,
    ST_BREW   = 3'd3,
    ST_COCOA  = 3'd4,
    ST_WATER  = 3'd5,
    ST_CREAM  = 3'd6,
    ST_DONE   = 3'd7
  } brew_step_e;

  // Recipe entry, laid out as the upstream recipe table (cmach_recipes.svh) stores it.
  typedef struct packed {
    logic       load_filter;
    logic [3:0] grinder_time;
    logic [3:0] pour_time;
    logic       high_press;
    logic [3:0] cocoa_time;
    logic [3:0] hot_water_time;
    logic       add_creamer;
  } coffee_recipe_t;

  // Duration of a step for a given recipe; zero means the step is skipped.
  function automatic logic [3:0] step_units(brew_step_e s, coffee_recipe_t r);
    logic [3:0] u;
    u = 4'd0;
    case (s)
      ST_FILTER: u = r.load_filter ? FILTER_TIME : 4'd0;
      ST_GRIND:  u = r.grinder_time;
      ST_BREW:   u = r.pour_time;
      ST_COCOA:  u = r.cocoa_time;
      ST_WATER:  u = r.hot_water_time;
      ST_CREAM:  u = r.add_creamer ? CREAM_TIME : 4'd0;
      default:   u = 4'd0;
    endcase
    return u;
  endfunction

  // First step after 'cur' with a non-zero duration, or DONE if none remain.
  // Walking downward lets the lowest qualifying step win without a break.
  function automatic brew_step_e next_step(brew_step_e cur, coffee_recipe_t r);
    brew_step_e nxt;
    nxt = ST_DONE;
    for (int i = 6; i >= 1; i--) begin
      if (i > int'(cur) && step_units(brew_step_e'(3'(i)), r) != 4'd0)
        nxt = brew_step_e'(3'(i));
    end
    return nxt;
  endfunction

  // Recipe array index for a drink/size pair (only meaningful for valid codes).
  function automatic logic [3:0] recipe_index(logic [2:0] drink, logic [1:0] size);
    return ({1'b0, drink} * 4'd3) + {2'b00, size};
  endfunction

endpackage

// File: rtl/cmach_step_timer.sv
// Step timer: prescaler of TICKS_PER_UNIT cycles feeding a 4-bit unit down-counter.
// Latency: 'expire' is high in the last cycle of a loaded duration (units*TICKS_PER_UNIT cycles).
// No backpressure; 'load' restarts the count and a zero load keeps the timer idle.
module cmach_step_timer #(
  parameter int TICKS_PER_UNIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] units,
  output logic       expire
);

  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_UNIT - 1);

  logic [PW-1:0] pre_q;
  logic [3:0]    unit_q;
  logic          wrap;

  assign wrap   = (pre_q == PRE_LAST);
  assign expire = (unit_q == 4'd1) && wrap;

  // Prescaler wraps every TICKS_PER_UNIT cycles and decrements the unit count; idle at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      unit_q <= 4'd0;
    end else if (load) begin
      pre_q  <= '0;
      unit_q <= units;
    end else if (unit_q != 4'd0) begin
      if (wrap) begin
        pre_q  <= '0;
        unit_q <= unit_q - 4'd1;
      end else begin
        pre_q  <= pre_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmach_brew_seq.sv
// Brew sequencer: latches a recipe on a valid order and walks FILTER..CREAM with timed steps.
// Latency: first step active the cycle after 'start' is sampled; 'done'/'err' are one-cycle pulses.
// No backpressure; 'start' is ignored outside IDLE. Optional abort via macro CMACH_CANCEL_EN.
module cmach_brew_seq
  import cmach_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  coffee_recipe_t [NUM_RECIPES-1:0]     recipes,
  input  logic                                 start,
  input  logic [2:0]                           drink,
  input  logic [1:0]                           size,
`ifdef CMACH_CANCEL_EN
  input  logic                                 cancel,
  output logic                                 cancelled,
`endif
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [2:0]                           step,
  output logic                                 filter_load,
  output logic                                 grinder_on,
  output logic                                 pump_on,
  output logic                                 high_press,
  output logic                                 cocoa_on,
  output logic                                 water_on,
  output logic                                 creamer_on
);

  brew_step_e     state, state_nxt;
  coffee_recipe_t rcp_q;
  coffee_recipe_t sel_rcp;
  coffee_recipe_t cur_rcp;
  logic           order_ok;
  logic           accept;
  logic           reject;
  logic           abort;
  logic           err_q;
  logic           timer_load;
  logic [3:0]     timer_units;
  logic           expire;

  assign order_ok = (drink <= DRINK_DRIP) && (size <= SIZE_L);
  assign sel_rcp  = order_ok ? recipes[recipe_index(drink, size)] : '0;
  assign accept   = (state == ST_IDLE) && start && order_ok;
  assign reject   = (state == ST_IDLE) && start && !order_ok;

`ifdef CMACH_CANCEL_EN
  assign abort = cancel && (state != ST_IDLE) && (state != ST_DONE);
`else
  assign abort = 1'b0;
`endif

  // In IDLE the recipe is not latched yet, so the search must use the selected entry.
  assign cur_rcp = (state == ST_IDLE) ? sel_rcp : rcp_q;

  // Every state change reloads the timer with the new step's duration (zero for IDLE/DONE).
  assign timer_load  = (state_nxt != state);
  assign timer_units = step_units(state_nxt, cur_rcp);

  cmach_step_timer #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .units  (timer_units),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: search forward for the next non-skipped step when the current one expires.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = next_step(ST_IDLE, sel_rcp);
      ST_DONE: state_nxt = ST_IDLE;
      default: if (expire) state_nxt = next_step(state, rcp_q);
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Latch the order's recipe so later table or order changes cannot affect the brew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rcp_q <= '0;
    else if (accept) rcp_q <= sel_rcp;
  end

  // Invalid-order pulse, raised the cycle after the rejected start is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= reject;
  end

`ifdef CMACH_CANCEL_EN
  logic canc_q;

  // Abort pulse, coincident with the first IDLE cycle after the cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) canc_q <= 1'b0;
    else     canc_q <= abort;
  end

  assign cancelled = canc_q;
`endif

  // Outputs decode directly from the state so an asynchronous reset drops every actuator at once.
  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    err         = err_q;
    step        = state;
    filter_load = 1'b0;
    grinder_on  = 1'b0;
    pump_on     = 1'b0;
    high_press  = 1'b0;
    cocoa_on    = 1'b0;
    water_on    = 1'b0;
    creamer_on  = 1'b0;
    case (state)
      ST_FILTER: filter_load = 1'b1;
      ST_GRIND:  grinder_on  = 1'b1;
      ST_BREW: begin
        pump_on    = 1'b1;
        high_press = rcp_q.high_press;
      end
      ST_COCOA:  cocoa_on    = 1'b1;
      ST_WATER:  water_on    = 1'b1;
      ST_CREAM:  creamer_on  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/cmach_brew_seq.md
# cmach_brew_seq

Brew sequencer for the coffee machine, directly downstream of the recipe table. It accepts a drink/size order, latches the matching `coffee_recipe_t` entry from the 15-entry recipe array, and drives the actuator enables through a fixed step order with timed durations. It reports `busy`, a one-cycle `done` pulse, and a one-cycle `err` pulse for invalid orders.

## Interface
- `TICKS_PER_UNIT`, default 4: clock cycles per recipe time unit; legal values are ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `recipes`  in  15 × `$bits(coffee_recipe_t)`  recipe array, index = drink*3 + size.
- `start`  in  1  order request; sampled in IDLE only.
- `drink`  in  3  0 mocha, 1 latte, 2 espresso, 3 americano, 4 drip.
- `size`  in  2  0 S, 1 M, 2 L.
- `cancel`  in  1  abort request; present only with `CMACH_CANCEL_EN`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse for an invalid order.
- `cancelled`  out  1  one-cycle abort pulse; present only with `CMACH_CANCEL_EN`.
- `step`  out  3  current state encoding.
- `filter_load`, `grinder_on`, `pump_on`, `high_press`, `cocoa_on`, `water_on`, `creamer_on`  out  1 each  actuator enables.

## Operation
- States, in order: IDLE, FILTER, GRIND, BREW, COCOA, WATER, CREAM, DONE.
- Step durations, in time units:
  - FILTER: `FILTER_TIME`, entered only if `load_filter`.
  - GRIND: `grinder_time`.
  - BREW: `pour_time`.
  - COCOA: `cocoa_time`.
  - WATER: `hot_water_time`.
  - CREAM: `CREAM_TIME`, entered only if `add_creamer`.
- A step with zero duration, or whose enable flag is 0, is skipped with no cycles spent. Next-step selection is a combinational search over the remaining steps.
- Actuator mapping: each enable is high exactly while in its step.
  - FILTER → `filter_load`.
  - GRIND → `grinder_on`.
  - BREW → `pump_on`, plus `high_press` = latched `high_press`.
  - COCOA → `cocoa_on`.
  - WATER → `water_on`.
  - CREAM → `creamer_on`.
- Order acceptance, in IDLE:
  - `start`=1 with `drink`≤4 and `size`≤2: latch `recipes[drink*3+size]` and move to the first non-skipped step.
  - If every step is skipped, go straight to DONE.
  - Invalid drink or size: pulse `err`, remain in IDLE, no actuator activity.
- `start` outside IDLE is ignored. The latched recipe is immune to later `recipes`, `drink` or `size` changes.
- DONE lasts one cycle with `done`=1, then returns to IDLE.
- Timing uses a prescaler counting 0..`TICKS_PER_UNIT`-1 and a 4-bit unit counter loaded with the step duration. The step ends when the unit counter reaches 1 and the prescaler wraps.

## Timing
- Reset values:
  - All outputs 0; `step`=IDLE.
  - Latched recipe cleared; counters cleared.
- Reset asserted mid-brew forces all actuators to 0 immediately (asynchronously).
- Latency: with `start` sampled at edge N, the first step is active from cycle N+1.
- Each step lasts exactly duration × `TICKS_PER_UNIT` cycles.
- Consecutive steps are back-to-back with no gap cycles. `done` asserts the cycle after the last step.
- `err` asserts the cycle after the invalid `start` is sampled.
- Maximum step duration is 15 units; the 4-bit counter never wraps.

## Configuration
- `CMACH_CANCEL_EN` defined:
  - `cancel` and `cancelled` ports exist.
  - `cancel`=1 in any non-IDLE state other than DONE forces all actuators off at the next edge and returns to IDLE. `cancelled` pulses in that cycle; `done` is not pulsed.
  - `cancel` in IDLE has no effect.
  - `cancel` in DONE is ignored; `done` still pulses.
- `CMACH_CANCEL_EN` undefined: both ports are absent and every accepted order runs to completion.

## Structure
- Package `cmach_pkg` holds:
  - `brew_step_e` (the state enum).
  - Drink and size codes, `NUM_RECIPES`=15, `NUM_SIZES`=3.
  - `FILTER_TIME`=2 and `CREAM_TIME`=2.
- `coffee_recipe_t` is taken from `cmach_recipes.svh`.
- Sub-module `cmach_step_timer` contains the prescaler plus unit counter. Interface: `load`, `units[3:0]`, output `expire`.

## Test plan
All scenarios use `TICKS_PER_UNIT`=1 with `start` sampled at edge 0, unless noted.
- Espresso S (drink 2, size 0):
  - `grinder_on` cycles 1–5.
  - `pump_on`+`high_press` cycles 6–7.
  - `done` at cycle 8; `filter_load`, `cocoa_on`, `water_on` and `creamer_on` never assert.
- Mocha S:
  - Grind cycles 1–3, brew 4–7, cocoa 8–9, water 10–11.
  - `done` at 12; FILTER and CREAM skipped.
- Drip S:
  - `filter_load` 1–2, grind 3–6.
  - `pump_on` 7–12 with `high_press`=0; water 13–24.
  - `done` at 25.
- Invalid orders: drink 5, then size 3 → `err` pulses at cycle 1 each time, `busy` stays 0, all actuators stay 0.
- Latte M with `TICKS_PER_UNIT`=4:
  - Grind 16 cycles, brew 24, water 32, cream 8.
  - `start` re-asserted mid-brew is ignored; `done` at cycle 81.
- With `CMACH_CANCEL_EN`: Americano L, `cancel` at cycle 8 → actuators 0 from cycle 9, `cancelled` pulse, `done` never asserts.
- Reset at cycle 3 of a brew clears all outputs; the next `start` after reset release works normally.
